uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of UART_TX.
- Recovers frames from serial line RX_IN: start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- Oversamples each bit Prescale times and votes on the mid-bit samples.
- Presents each checked byte on P_DATA with a one-cycle Data_Valid pulse; flags parity and stop-bit errors.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_W, 6, width of the Prescale port and of the edge counter.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  asynchronous active-low reset.
- RX_IN  input  1  serial line; idle high; synchronous to CLK (no internal synchronizer).
- Prescale  input  PRESCALE_W  clock cycles per bit; legal values 8, 16, 32.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even, 1 = odd.
- P_DATA  output  DATA_WIDTH  last good byte received.
- Data_Valid  output  1  one-cycle pulse, P_DATA updated.
- Par_Err  output  1  one-cycle pulse, parity mismatch.
- Stp_Err  output  1  one-cycle pulse, stop bit sampled 0.

Behaviour:
- Reset (RST=0, any time including mid-frame):
  - State goes to IDLE; counters and shift register clear.
  - P_DATA=0, Data_Valid=0, Par_Err=0, Stp_Err=0.
- Counters:
  - edge_cnt runs 0..Prescale-1 within each bit and wraps at Prescale-1.
  - bit_cnt increments on each wrap.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On RX_IN=0 at a posedge, that cycle is cycle 0, edge_cnt=0.
  - Go to START.
  - Latch Prescale, PAR_EN and PAR_TYP for the whole frame; changes mid-frame are ignored.
- Sampling:
  - Take samples at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
  - Bit value = majority of the 3 samples, resolved at edge_cnt = Prescale/2+2.
- START:
  - If the voted bit is 1, treat it as a glitch: return to IDLE at the next cycle with no outputs.
  - Otherwise go to DATA at the wrap.
- DATA:
  - Shift the voted bits in LSB first, 8 bits.
  - At the wrap of bit 7, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY:
  - Expected parity = XOR of the 8 data bits XOR PAR_TYP.
  - Mismatch is recorded internally.
- STOP:
  - Voted value 0 is recorded as a stop error.
- Frame end:
  - Frame length is (10+PAR_EN)*Prescale cycles.
  - At the posedge closing the last STOP cycle, i.e. cycle (10+PAR_EN)*Prescale, the flags become visible for one cycle:
    - No errors: Data_Valid=1 and P_DATA = received byte.
    - Parity mismatch: Par_Err=1, Data_Valid=0.
    - Stop error: Stp_Err=1, Data_Valid=0.
  - Both errors may pulse together.
  - On any error, P_DATA holds its previous value.
- Back-to-back frames:
  - If RX_IN=0 in the cycle after STOP ends, that cycle is cycle 0 of the next frame.
  - There is no dead time beyond the mandatory stop bit.
- A line stuck low after a stop error produces repeated frames of 0x00 with Stp_Err; no lockup.
- Prescale values other than 8/16/32 give undefined output. Prescale is never sampled as 0.

Test Plan:
- Reset mid-frame:
  - Stimulus: Prescale=8; drive 0xA5 frame; pull RST low at cycle 30, release.
  - Required: all outputs 0 immediately; no Data_Valid.
  - Required: the next clean frame is received correctly.
- Good frame, no parity:
  - Stimulus: Prescale=8, PAR_EN=0; drive 0xA5 (line 0,1,0,1,0,0,1,0,1,1), 8 cycles per bit.
  - Required: Data_Valid single pulse at cycle 80, P_DATA=0xA5, Par_Err=Stp_Err=0.
- Good frame, even parity:
  - Stimulus: Prescale=16, PAR_EN=1, PAR_TYP=0; drive 0x5A with parity bit 0.
  - Required: Data_Valid at cycle 176, P_DATA=0x5A.
- Bad parity, odd:
  - Stimulus: Prescale=8, PAR_EN=1, PAR_TYP=1; drive 0x3C with parity bit 0 (correct value is 1).
  - Required: Par_Err pulse at cycle 88, Data_Valid=0, P_DATA unchanged.
- Bad stop bit:
  - Stimulus: 0x81, stop bit driven 0.
  - Required: Stp_Err pulse, no Data_Valid.
- Start glitch, then back-to-back frames:
  - Stimulus: RX_IN low 2 cycles, then high.
  - Required: no outputs; FSM back in IDLE.
  - Stimulus: then send 0x12 and 0x34 back-to-back.
  - Required: two Data_Valid pulses exactly 10*Prescale cycles apart, values 0x12 then 0x34.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Each bit is oversampled Prescale times and decided by a 3-sample majority vote around mid-bit.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    localparam int BCW = $clog2(DATA_WIDTH + 4);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [PRESCALE_W-1:0]   r_ps;
    logic [PRESCALE_W-1:0]   r_edge_cnt;
    logic [BCW-1:0]          r_bit_cnt;
    logic                    r_par_en;
    logic                    r_par_typ;
    logic [2:0]              r_samp;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_par_bad;
    logic                    r_stp_bad;

    logic [PRESCALE_W-1:0]   w_half;
    logic                    w_wrap;
    logic                    w_sample;
    logic                    w_resolve;
    logic                    w_vote;
    logic                    w_start;
    logic                    w_frame_end;

    // Frame-relative timing uses the latched prescale so a mid-frame change cannot disturb it.
    assign w_half      = r_ps >> 1;
    assign w_wrap      = (r_edge_cnt == r_ps - PRESCALE_W'(1));
    assign w_sample    = (r_edge_cnt == w_half - PRESCALE_W'(1)) ||
                         (r_edge_cnt == w_half) ||
                         (r_edge_cnt == w_half + PRESCALE_W'(1));
    assign w_resolve   = (r_edge_cnt == w_half + PRESCALE_W'(2));
    assign w_vote      = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
    assign w_start     = (r_state == IDLE) && !RX_IN;
    assign w_frame_end = (r_state == STOP) && w_wrap;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!RX_IN) w_next = START;
            START: begin
                if (w_resolve && w_vote) begin
                    w_next = IDLE;
                end else if (w_wrap) begin
                    w_next = DATA;
                end
            end
            DATA:    if (w_wrap && r_bit_cnt == BCW'(DATA_WIDTH)) w_next = r_par_en ? PARITY : STOP;
            PARITY:  if (w_wrap) w_next = STOP;
            STOP:    if (w_wrap) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ps       <= '0;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_samp     <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_stp_bad  <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            if (w_start) begin
                // The falling-edge sample is edge 0, so the next sample is edge 1.
                r_ps       <= Prescale;
                r_par_en   <= PAR_EN;
                r_par_typ  <= PAR_TYP;
                r_edge_cnt <= PRESCALE_W'(1);
                r_bit_cnt  <= '0;
                r_par_bad  <= 1'b0;
                r_stp_bad  <= 1'b0;
            end else if (r_state != IDLE) begin
                if (w_wrap) begin
                    r_edge_cnt <= '0;
                    r_bit_cnt  <= r_bit_cnt + BCW'(1);
                end else begin
                    r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
                end
                if (w_sample) begin
                    r_samp <= {r_samp[1:0], RX_IN};
                end
                if (w_resolve) begin
                    case (r_state)
                        DATA:    r_shift   <= {w_vote, r_shift[DATA_WIDTH-1:1]};
                        PARITY:  r_par_bad <= ((^r_shift) ^ r_par_typ) != w_vote;
                        STOP:    r_stp_bad <= !w_vote;
                        default: ;
                    endcase
                end
                if (w_frame_end) begin
                    Data_Valid <= !r_par_bad && !r_stp_bad;
                    Par_Err    <= r_par_bad;
                    Stp_Err    <= r_stp_bad;
                    if (!r_par_bad && !r_stp_bad) begin
                        P_DATA <= r_shift;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: line frames built bit by bit, result pulses logged with their cycle
// numbers and compared against hand-computed bytes and frame lengths.
module tb_uart_rx;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stp_Err;

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } dv_ev_t;

    int     cyc = 0;
    dv_ev_t dv_q[$];
    int     pe_q[$];
    int     se_q[$];
    int     n_checks = 0;
    int     n_pass = 0;
    int     b_dv, b_pe, b_se;

    always @(posedge CLK) cyc <= cyc + 1;

    // Outputs are sampled on the falling edge, half a cycle clear of the active edge.
    always @(negedge CLK) begin
        if (Data_Valid === 1'b1) dv_q.push_back('{cyc: cyc, data: P_DATA});
        if (Par_Err === 1'b1)    pe_q.push_back(cyc);
        if (Stp_Err === 1'b1)    se_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        b_dv = dv_q.size();
        b_pe = pe_q.size();
        b_se = se_q.size();
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Drives one frame starting at a falling edge; n_cycles >= 0 truncates it.
    // scramble changes the frame settings one cycle in, which the receiver must ignore.
    task automatic drive_frame(input logic [7:0] data, input int ps, input bit par_en,
                               input bit par_typ, input bit par_bit, input bit stop_bit,
                               input int n_cycles, input bit scramble, output int t0);
        logic [10:0] line;
        int          nb;
        int          total;
        line = '1;
        line[0] = 1'b0;
        for (int i = 0; i < 8; i++) line[i+1] = data[i];
        if (par_en) begin
            line[9]  = par_bit;
            line[10] = stop_bit;
            nb = 11;
        end else begin
            line[9] = stop_bit;
            nb = 10;
        end
        Prescale = 6'(ps);
        PAR_EN   = par_en;
        PAR_TYP  = par_typ;
        total = nb * ps;
        if (n_cycles >= 0 && n_cycles < total) total = n_cycles;
        t0 = cyc;
        for (int c = 0; c < total; c++) begin
            RX_IN = line[c / ps];
            if (scramble && c == 1) begin
                Prescale = 6'd8;
                PAR_EN   = ~par_en;
                PAR_TYP  = ~par_typ;
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        int t0;
        int t1;
        RST      = 1'b0;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_p_data", 32'(P_DATA), 32'h0);
        check("rst_dv", 32'(Data_Valid), 32'h0);
        check("rst_par_err", 32'(Par_Err), 32'h0);
        check("rst_stp_err", 32'(Stp_Err), 32'h0);
        RST = 1'b1;
        idle(5);

        // 0xA5, no parity, Prescale 8: valid at cycle 80.
        mark();
        drive_frame(8'hA5, 8, 0, 0, 0, 1, -1, 0, t0);
        idle(5);
        check("a5_dv_count", 32'(dv_q.size() - b_dv), 32'd1);
        if (dv_q.size() > b_dv) begin
            check("a5_dv_cycle", 32'(dv_q[b_dv].cyc - t0), 32'd80);
            check("a5_data", 32'(dv_q[b_dv].data), 32'hA5);
        end
        check("a5_par_err", 32'(pe_q.size() - b_pe), 32'd0);
        check("a5_stp_err", 32'(se_q.size() - b_se), 32'd0);
        check("a5_p_data_hold", 32'(P_DATA), 32'hA5);

        // 0x5A, even parity bit 0, Prescale 16, settings disturbed mid-frame: valid at cycle 176.
        mark();
        drive_frame(8'h5A, 16, 1, 0, 0, 1, -1, 1, t0);
        idle(5);
        check("5a_dv_count", 32'(dv_q.size() - b_dv), 32'd1);
        if (dv_q.size() > b_dv) begin
            check("5a_dv_cycle", 32'(dv_q[b_dv].cyc - t0), 32'd176);
            check("5a_data", 32'(dv_q[b_dv].data), 32'h5A);
        end
        check("5a_par_err", 32'(pe_q.size() - b_pe), 32'd0);
        check("5a_stp_err", 32'(se_q.size() - b_se), 32'd0);

        // 0x3C, odd parity wants 1, driven 0: parity error at cycle 88.
        mark();
        drive_frame(8'h3C, 8, 1, 1, 0, 1, -1, 0, t0);
        idle(5);
        check("3c_pe_count", 32'(pe_q.size() - b_pe), 32'd1);
        if (pe_q.size() > b_pe) check("3c_pe_cycle", 32'(pe_q[b_pe] - t0), 32'd88);
        check("3c_dv_count", 32'(dv_q.size() - b_dv), 32'd0);
        check("3c_stp_err", 32'(se_q.size() - b_se), 32'd0);
        check("3c_p_data_hold", 32'(P_DATA), 32'h5A);

        // 0x81 with stop bit 0: stop error at cycle 80.
        mark();
        drive_frame(8'h81, 8, 0, 0, 0, 0, -1, 0, t0);
        idle(5);
        check("81_se_count", 32'(se_q.size() - b_se), 32'd1);
        if (se_q.size() > b_se) check("81_se_cycle", 32'(se_q[b_se] - t0), 32'd80);
        check("81_dv_count", 32'(dv_q.size() - b_dv), 32'd0);
        check("81_par_err", 32'(pe_q.size() - b_pe), 32'd0);
        check("81_p_data_hold", 32'(P_DATA), 32'h5A);

        // Reset pulled at cycle 30 of a frame.
        mark();
        drive_frame(8'hA5, 8, 0, 0, 0, 1, 30, 0, t0);
        RST   = 1'b0;
        RX_IN = 1'b1;
        #1;
        check("midrst_p_data", 32'(P_DATA), 32'h0);
        check("midrst_dv", 32'(Data_Valid), 32'h0);
        check("midrst_par_err", 32'(Par_Err), 32'h0);
        check("midrst_stp_err", 32'(Stp_Err), 32'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        idle(100);
        check("midrst_no_dv", 32'(dv_q.size() - b_dv), 32'd0);
        mark();
        drive_frame(8'hC3, 8, 0, 0, 0, 1, -1, 0, t0);
        idle(5);
        check("c3_dv_count", 32'(dv_q.size() - b_dv), 32'd1);
        if (dv_q.size() > b_dv) begin
            check("c3_dv_cycle", 32'(dv_q[b_dv].cyc - t0), 32'd80);
            check("c3_data", 32'(dv_q[b_dv].data), 32'hC3);
        end

        // Two-cycle start glitch must be rejected.
        mark();
        Prescale = 6'd8;
        RX_IN    = 1'b0;
        repeat (2) @(negedge CLK);
        idle(100);
        check("glitch_dv", 32'(dv_q.size() - b_dv), 32'd0);
        check("glitch_pe", 32'(pe_q.size() - b_pe), 32'd0);
        check("glitch_se", 32'(se_q.size() - b_se), 32'd0);

        // Back-to-back 0x12 then 0x34 with no gap after the stop bit.
        mark();
        drive_frame(8'h12, 8, 0, 0, 0, 1, -1, 0, t0);
        drive_frame(8'h34, 8, 0, 0, 0, 1, -1, 0, t1);
        idle(5);
        check("b2b_dv_count", 32'(dv_q.size() - b_dv), 32'd2);
        check("b2b_start_gap", 32'(t1 - t0), 32'd80);
        if (dv_q.size() > b_dv + 1) begin
            check("b2b_first_cycle", 32'(dv_q[b_dv].cyc - t0), 32'd80);
            check("b2b_first_data", 32'(dv_q[b_dv].data), 32'h12);
            check("b2b_spacing", 32'(dv_q[b_dv+1].cyc - dv_q[b_dv].cyc), 32'd80);
            check("b2b_second_data", 32'(dv_q[b_dv+1].data), 32'h34);
        end
        check("b2b_errors", 32'((pe_q.size() - b_pe) + (se_q.size() - b_se)), 32'd0);

        // Line stuck low for 200 cycles: two 0x00 frames with stop errors, then a frame whose
        // upper four data bits and stop bit see the released line, giving 0xF0 at cycle 240.
        mark();
        t0    = cyc;
        RX_IN = 1'b0;
        repeat (200) @(negedge CLK);
        idle(60);
        check("stuck_se_count", 32'(se_q.size() - b_se), 32'd2);
        if (se_q.size() > b_se + 1) begin
            check("stuck_se0_cycle", 32'(se_q[b_se] - t0), 32'd80);
            check("stuck_se1_cycle", 32'(se_q[b_se+1] - t0), 32'd160);
        end
        check("stuck_dv_count", 32'(dv_q.size() - b_dv), 32'd1);
        if (dv_q.size() > b_dv) begin
            check("stuck_dv_cycle", 32'(dv_q[b_dv].cyc - t0), 32'd240);
            check("stuck_dv_data", 32'(dv_q[b_dv].data), 32'hF0);
        end
        check("stuck_pe_count", 32'(pe_q.size() - b_pe), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
